softmax_out_writer: RTL
=======================

Name: softmax_out_writer

Overview:
- Downstream of the softmax core. Captures each result it produces (`outp0`, qualified by `done` asserted for one cycle per element).
- Packs PACK consecutive results into one wide memory word. Buffers packed words in a small FIFO, because the softmax pipeline cannot stall.
- Writes buffered words to the output on-chip memory with a ready/valid-style handshake, starting at a base address latched on init.
- Signals completion after a flush request once all data has been written.

Parameters:
- DATAWIDTH, 16, width of one softmax result (fp16).
- PACK, 4, results per memory word; power of two, ≥1.
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, ≥2.
- OUT_ADDRSIZE, 4, output memory address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  latch out_start_addr; clear counters, pack register, FIFO and flags.
- out_start_addr  in  OUT_ADDRSIZE  first output word address.
- in_valid  in  1  result strobe (softmax done).
- in_data  in  DATAWIDTH  result value (softmax outp0).
- flush  in  1  end of stream; pad and drain the partial word.
- mem_we  out  1  write request; high whenever the FIFO is non-empty.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_waddr  out  OUT_ADDRSIZE  write address.
- mem_wdata  out  DATAWIDTH*PACK  packed word; lane 0 in the LSBs.
- busy  out  1  high in RUN or DRAIN.
- finished  out  1  one-cycle pulse when a drain completes.
- overflow  out  1  sticky; a packed word was dropped.
- words_written  out  OUT_ADDRSIZE+1  count of accepted writes since init.

Behaviour:
- **Reset (reset=0):**
  - State = IDLE.
  - All outputs 0: mem_we, mem_waddr, mem_wdata, busy, finished, overflow, words_written.
  - Lane counter, FIFO pointers and FIFO occupancy all 0.
  - Asserting reset mid-transfer abandons all data immediately.
- **init (any state):**
  - Applies only when reset=1.
  - Next state RUN; base/write address <= out_start_addr.
  - Lane counter, FIFO, overflow and words_written cleared.
  - init takes priority over in_valid and flush in the same cycle; that in_valid is ignored.
- **Packing (RUN only):**
  - On in_valid, in_data is written into lane `lane_cnt` of the pack register and lane_cnt increments.
  - When lane_cnt==PACK-1 and in_valid: the completed word (including this cycle's data) is pushed into the FIFO next edge, and lane_cnt wraps to 0.
  - Latency from the last in_valid of a word to mem_we high is 1 cycle if the FIFO was empty.
  - in_valid in IDLE or DRAIN is ignored.
- **FIFO push/pop:**
  - Pop occurs when mem_we && mem_ready. On each pop: mem_waddr increments and wraps modulo 2^OUT_ADDRSIZE; words_written increments and saturates at all-ones.
  - mem_wdata and mem_waddr are registered from the FIFO head and the address counter. They stay stable while mem_we=1 && mem_ready=0.
  - Push and pop in the same cycle: occupancy unchanged. This is legal even when the FIFO is full, because the pop frees the slot first.
  - Push when full and no pop: the word is dropped, overflow <= 1 (sticky until init or reset), and lane_cnt still wraps.
- **flush (RUN):**
  - If lane_cnt != 0: the partial word is pushed on the next edge with unfilled lanes zero. Full-FIFO rules apply.
  - If lane_cnt == 0: nothing is pushed.
  - An in_valid in the same cycle as flush is packed first, then the flush applies to the result. If that in_valid completes the word, only the full word is pushed.
  - State -> DRAIN.
- **DRAIN:**
  - Continue popping until the FIFO is empty.
  - On the edge the FIFO becomes empty (or immediately, if already empty): finished pulses 1 cycle and state -> IDLE.
  - flush in IDLE or DRAIN is ignored.
- **busy:** 1 in RUN and DRAIN, 0 in IDLE.

Test Plan:
1. **Basic pack:** init with out_start_addr=3, mem_ready=1; 8 in_valid pulses with data 0x3C00..0x3C07 → two writes: addr 3 with wdata {0x3C03,0x3C02,0x3C01,0x3C00}, then addr 4 with {0x3C07..0x3C04}; words_written=2.
2. **Partial flush:** 5 results (0x0001..0x0005) then flush → writes {3,2,1,0}-lane word, then {0,0,0,0x0005}; finished pulses once; busy falls the same cycle; state IDLE.
3. **Backpressure/overflow:** mem_ready=0; 20 results (5 words) → 4 words buffered, 5th dropped, overflow=1. Then mem_ready=1 → exactly 4 writes, data unchanged while stalled.
4. **Full with simultaneous pop:** FIFO full, mem_ready=1 on the same cycle a word completes → no overflow, occupancy stays 4.
5. **Address wrap:** out_start_addr=15, 2 full words → mem_waddr 15 then 0.
6. **Async reset mid-DRAIN:** pull reset low between clock edges → mem_we, busy, overflow and words_written are 0 immediately. After release: no writes until init.

Source files
------------

// File: rtl/softmax_out_writer.sv
// Packs softmax results PACK-wide into memory words, buffers them in a small FIFO
// (the softmax pipeline never stalls) and writes them out with a ready/valid handshake.
module softmax_out_writer #(
   parameter int DATAWIDTH    = 16,
   parameter int PACK         = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int OUT_ADDRSIZE = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          init,
   input  logic [OUT_ADDRSIZE-1:0]       out_start_addr,
   input  logic                          in_valid,
   input  logic [DATAWIDTH-1:0]          in_data,
   input  logic                          flush,
   output logic                          mem_we,
   input  logic                          mem_ready,
   output logic [OUT_ADDRSIZE-1:0]       mem_waddr,
   output logic [DATAWIDTH*PACK-1:0]     mem_wdata,
   output logic                          busy,
   output logic                          finished,
   output logic                          overflow,
   output logic [OUT_ADDRSIZE:0]         words_written
);

   localparam int WORD_W = DATAWIDTH * PACK;
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_reg;
   logic [LANE_W-1:0]   lane_cnt_reg;
   logic [LANE_W-1:0]   lane_inc;
   logic [LANE_W-1:0]   lane_cnt_next;
   logic [WORD_W-1:0]   pack_reg;
   logic [WORD_W-1:0]   pack_word;
   logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [CNT_W-1:0]    count_next;
   logic [WORD_W-1:0]   head_next;

   logic take;
   logic last_lane;
   logic full_push;
   logic flush_push;
   logic push_req;
   logic push_ok;
   logic pop;

   assign take      = in_valid && (state_reg == RUN) && !init;
   assign last_lane = (lane_cnt_reg == LANE_W'(PACK - 1));

   // Current pack contents with this cycle's result already merged into its lane.
   generate
      for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
         assign pack_word[gi*DATAWIDTH +: DATAWIDTH] =
            (take && (lane_cnt_reg == LANE_W'(gi))) ? in_data
                                                    : pack_reg[gi*DATAWIDTH +: DATAWIDTH];
      end
   endgenerate

   always_comb begin
      lane_inc = lane_cnt_reg;
      if (take) begin
         lane_inc = last_lane ? '0 : lane_cnt_reg + 1'b1;
      end
      full_push     = take && last_lane;
      flush_push    = (state_reg == RUN) && flush && !init && (lane_inc != '0);
      push_req      = full_push || flush_push;
      lane_cnt_next = push_req ? '0 : lane_inc;
      pop           = mem_we && mem_ready;
      // A simultaneous pop frees a slot, so a full FIFO can still accept the push.
      push_ok       = push_req && ((count_reg != CNT_W'(FIFO_DEPTH)) || pop);
      count_next    = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
      if ((count_reg - CNT_W'(pop)) == '0) begin
         head_next = pack_word;
      end else begin
         head_next = fifo_mem[rd_ptr_reg + PTR_W'(pop)];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= pack_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         lane_cnt_reg  <= '0;
         pack_reg      <= '0;
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         mem_we        <= 1'b0;
         mem_waddr     <= '0;
         mem_wdata     <= '0;
         busy          <= 1'b0;
         finished      <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else if (init) begin
         state_reg     <= RUN;
         lane_cnt_reg  <= '0;
         pack_reg      <= '0;
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         mem_we        <= 1'b0;
         mem_waddr     <= out_start_addr;
         mem_wdata     <= '0;
         busy          <= 1'b1;
         finished      <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else begin
         finished     <= 1'b0;
         lane_cnt_reg <= lane_cnt_next;
         if (push_req) begin
            pack_reg <= '0;
         end else if (take) begin
            pack_reg <= pack_word;
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            mem_waddr  <= mem_waddr + 1'b1;
            if (words_written != '1) begin
               words_written <= words_written + 1'b1;
            end
         end
         count_reg <= count_next;
         mem_we    <= (count_next != '0);
         if (count_next != '0) begin
            mem_wdata <= head_next;
         end
         case (state_reg)
            RUN: begin
               if (flush) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_next == '0) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  finished  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
